instr_fetch_unit: RTL

//   Fetch stage directly upstream of the instruction decoders (decode_upperimm_inst and

---
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetch stage feeding the instruction decoders. Owns the PC,
//                issues one word read at a time to instruction memory and
//                presents {instruction_code, pc} to decode over valid/ready.
//                A redirect loads a new PC and discards any stale response.
//  Ports       : clk, rst_n                    - clock, async active-low reset
//                imem_req_valid/ready, addr    - instruction memory request
//                imem_rsp_valid/data           - instruction memory response
//                redirect_valid/pc             - branch/jump target load
//                fetch_valid/ready             - decode handshake
//                instruction_code, pc          - fetched word and its address
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] instruction_code,
    output logic [31:0] pc
);

    localparam logic [31:0] c_PC_STEP    = 32'd4;
    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state;
    logic [31:0] r_pc_q;
    logic [31:0] w_pc_q;
    logic        r_req_valid;
    logic        w_req_valid;
    logic        r_fetch_valid;
    logic        w_fetch_valid;
    logic [31:0] r_instr;
    logic [31:0] w_instr;
    logic [31:0] r_pc;
    logic [31:0] w_pc;
    logic        w_req_fire;

    // r_req_valid is only ever high in S_REQ, so this is the accepted-request
    // strobe. It stays low for the first cycle after reset release, which
    // keeps the request line low while rst_n is asserted.
    assign w_req_fire = r_req_valid & imem_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_REQ;
            r_pc_q        <= RESET_PC;
            r_req_valid   <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_pc          <= RESET_PC;
        end else begin
            r_state       <= w_state;
            r_pc_q        <= w_pc_q;
            r_req_valid   <= w_req_valid;
            r_fetch_valid <= w_fetch_valid;
            r_instr       <= w_instr;
            r_pc          <= w_pc;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_pc_q        = r_pc_q;
        w_fetch_valid = r_fetch_valid;
        w_instr       = r_instr;
        w_pc          = r_pc;

        if (redirect_valid) begin
            w_pc_q        = redirect_pc & c_ALIGN_MASK;
            w_fetch_valid = 1'b0;
            w_instr       = NOP_INSTR;
            // Any request already accepted by memory must have its response
            // absorbed in S_DRAIN before a new request may be issued.
            case (r_state)
                S_REQ:   w_state = w_req_fire     ? S_DRAIN : S_REQ;
                S_WAIT:  w_state = imem_rsp_valid ? S_REQ   : S_DRAIN;
                S_HOLD:  w_state = S_REQ;
                S_DRAIN: w_state = imem_rsp_valid ? S_REQ   : S_DRAIN;
                default: w_state = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_req_fire) begin
                        w_state = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        w_instr       = imem_rsp_data;
                        w_pc          = r_pc_q;
                        w_fetch_valid = 1'b1;
                        w_pc_q        = r_pc_q + c_PC_STEP;
                        w_state       = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (fetch_ready) begin
                        w_fetch_valid = 1'b0;
                        w_instr       = NOP_INSTR;
                        w_state       = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rsp_valid) begin
                        w_state = S_REQ;
                    end
                end
                default: w_state = S_REQ;
            endcase
        end

        w_req_valid = (w_state == S_REQ);
    end

    assign imem_req_valid   = r_req_valid;
    assign imem_addr        = r_pc_q;
    assign fetch_valid      = r_fetch_valid;
    assign instruction_code = r_instr;
    assign pc               = r_pc;

endmodule
`default_nettype wire
